// File: rtl/fetch_branch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_branch_sequencer
//  Description : Owns the program counter of the 16-bit core. Sequences
//                instruction fetch over a req/ack memory port, holds the
//                fetched word in ir until downstream issues it, redirects the
//                PC on a taken branch (with a one-cycle flush pulse), keeps
//                the architectural flags for the BranchUnit and stops in HALT.
//  Ports       :
//    clk, rst_n                  clock / asynchronous active-low reset
//    imem_req, imem_addr         fetch request and address (= PC)
//    imem_ack, imem_rdata        memory acknowledge and returned instruction
//    ir, ir_valid, pc_out        instruction register, valid, its address
//    stall                       downstream hold of issue
//    is_branch                   decoder: ir is a branch
//    branch_taken, branch_target BranchUnit decision and destination
//    flags_in, flags_we          ALU flags and their capture enable
//    stored_flags                registered flags to the BranchUnit
//    flush                       one-cycle pulse after a taken branch
//    halted                      sequencer stopped
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_branch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [15:0] pc_out,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [3:0]  flags_in,
    input  logic        flags_we,
    output logic [3:0]  stored_flags,
    output logic        flush,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_pc, w_pc_next;
    logic [15:0] r_ir, w_ir_next;
    logic [15:0] r_pc_out, w_pc_out_next;
    logic        r_ir_valid, w_ir_valid_next;
    logic        r_flush, w_flush_next;
    logic        r_halted, w_halted_next;
    logic [3:0]  r_flags;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= 16'h0000;
            r_pc_out   <= 16'h0000;
            r_ir_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_pc_out   <= w_pc_out_next;
            r_ir_valid <= w_ir_valid_next;
            r_flush    <= w_flush_next;
            r_halted   <= w_halted_next;
        end
    end

    // Flags are captured independently of the sequencer state. A branch
    // resolved on the same edge still sees the old value because the
    // BranchUnit reads stored_flags combinationally before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'h0;
        end else if (flags_we) begin
            r_flags <= flags_in;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_pc_out_next   = r_pc_out;
        w_ir_valid_next = r_ir_valid;
        w_halted_next   = r_halted;
        // flush is a pulse: it is only ever raised for a single cycle
        w_flush_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_ir_next       = imem_rdata;
                    w_pc_out_next   = r_pc;
                    w_pc_next       = r_pc + 16'd1;
                    w_ir_valid_next = 1'b1;
                    w_state_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    w_ir_valid_next = 1'b0;
                    // HALT is tested first so it wins over a branch decode
                    if (r_ir[15:12] == HALT_OPCODE) begin
                        w_halted_next = 1'b1;
                        w_state_next  = S_HALT;
                    end else begin
                        if (is_branch && branch_taken) begin
                            w_pc_next    = branch_target;
                            w_flush_next = 1'b1;
                        end
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                w_halted_next = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = r_pc;
    assign ir           = r_ir;
    assign ir_valid     = r_ir_valid;
    assign pc_out       = r_pc_out;
    assign stored_flags = r_flags;
    assign flush        = r_flush;
    assign halted       = r_halted;

endmodule
`default_nettype wire
